mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one memory
// through a three-state FSM with alternating priority on ties.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mbe,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_addr,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_mbe,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic        busy,
    output logic        owner,
    output logic        d_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic        last_grant_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  mbe_r;
    logic        write_r;
    logic        d_err_r;
    logic        d_req_s;
    logic        grant_i_s;
    logic        grant_d_s;
    logic        serving_s;

    // Arbitration: on a tie the port that was not served last wins.
    always_comb begin
        d_req_s   = d_read | d_write;
        grant_d_s = d_req_s & (~i_read | ~last_grant_r);
        grant_i_s = i_read & ~grant_d_s;
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_next_s = SERVE_D;
                end else if (grant_i_s) begin
                    state_next_s = SERVE_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, grant history, latched request and sticky error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            mbe_r        <= 4'h0;
            write_r      <= 1'b0;
            d_err_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == IDLE) begin
                if (grant_d_s) begin
                    addr_r  <= d_addr;
                    wdata_r <= d_wdata;
                    mbe_r   <= d_mbe;
                    // A simultaneous read+write is demoted to a write and flagged.
                    write_r <= d_write;
                    if (d_read && d_write) begin
                        d_err_r <= 1'b1;
                    end
                end else if (grant_i_s) begin
                    addr_r  <= i_addr;
                    wdata_r <= 32'h0000_0000;
                    mbe_r   <= 4'hF;
                    write_r <= 1'b0;
                end
            end else if (pmem_resp) begin
                last_grant_r <= (state_r == SERVE_D);
            end
        end
    end

    // Memory-side and requester-side outputs, all gated by the serving state
    always_comb begin
        serving_s  = (state_r == SERVE_I) || (state_r == SERVE_D);
        pmem_read  = serving_s & ~write_r;
        pmem_write = serving_s & write_r;
        pmem_addr  = serving_s ? (addr_r & 32'hFFFF_FFFC) : 32'h0000_0000;
        pmem_wdata = serving_s ? wdata_r : 32'h0000_0000;
        pmem_mbe   = serving_s ? mbe_r : 4'h0;
        i_resp     = (state_r == SERVE_I) & pmem_resp;
        d_resp     = (state_r == SERVE_D) & pmem_resp;
        i_rdata    = i_resp ? pmem_rdata : 32'h0000_0000;
        d_rdata    = d_resp ? pmem_rdata : 32'h0000_0000;
        busy       = serving_s;
        if (state_r == SERVE_D) begin
            owner = 1'b1;
        end else if (state_r == SERVE_I) begin
            owner = 1'b0;
        end else begin
            owner = last_grant_r;
        end
        d_err = d_err_r;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single transactions,
// hand-written corner sequences, and a response scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mbe;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;
    logic        busy;
    logic        owner;
    logic        d_err;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mbe(d_mbe), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_mbe(pmem_mbe), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .busy(busy), .owner(owner), .d_err(d_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic [3:0]  lat;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mbe;
        logic        exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } sb_t;

    vec_t vecs [5];
    sb_t  sb [$];
    int   checks = 0;
    int   errors = 0;
    bit   mem_en = 1'b1;
    int   mem_lat = 0;
    int   mcnt = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0060) return 32'h0000_0013;
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: advance to the falling edge, check invariants, score any response.
    task automatic tick();
        logic ok;
        sb_t  e;
        @(negedge clk);
        ok = !(pmem_read && pmem_write) && !(i_resp && d_resp)
             && (i_resp || i_rdata == 32'h0) && (d_resp || d_rdata == 32'h0)
             && (busy || (!pmem_read && !pmem_write && pmem_addr == 32'h0
                          && pmem_wdata == 32'h0 && pmem_mbe == 4'h0));
        check("invariants", {31'h0, ok}, 32'h1);
        if (i_resp || d_resp) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {30'h0, d_resp, i_resp}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("resp_port", {31'h0, d_resp}, {31'h0, e.port});
                check("resp_data", d_resp ? d_rdata : i_rdata, e.rdata);
            end
        end
    endtask

    // Memory model: answers a strobe after mem_lat wait cycles.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                if (pmem_read || pmem_write) begin
                    if (mcnt == mem_lat) begin
                        pmem_resp  = 1'b1;
                        pmem_rdata = mem_data(pmem_addr);
                        mcnt       = 0;
                    end else begin
                        pmem_resp  = 1'b0;
                        pmem_rdata = 32'h0;
                        mcnt       = mcnt + 1;
                    end
                end else begin
                    pmem_resp  = 1'b0;
                    pmem_rdata = 32'h0;
                    mcnt       = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    initial begin
        int  cyc;
        int  n;
        int  rc [4];
        bit  got;
        bit  seen;
        vec_t v;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'h0, 4'd1,
                    32'h0000_0060, 4'hF, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_1003, 32'hAABB_CCDD, 4'b1000, 4'd0,
                    32'h0000_1000, 4'b1000, 1'b1, 32'hAABB_CCDD};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_2002, 32'h1111_2222, 4'h3, 4'd2,
                    32'h0000_2000, 4'h3, 1'b0, 32'h1111_2222};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 4'd0,
                    32'hFFFF_FFFC, 4'hF, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0005, 32'h0BAD_F00D, 4'b0101, 4'd3,
                    32'h0000_0004, 4'b0101, 1'b1, 32'h0BAD_F00D};

        rst = 1'b0; i_read = 1'b0; i_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_mbe = 4'h0;
        repeat (2) tick();
        check("rst_pmem_read", {31'h0, pmem_read}, 32'h0);
        check("rst_pmem_write", {31'h0, pmem_write}, 32'h0);
        check("rst_pmem_addr", pmem_addr, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_owner", {31'h0, owner}, 32'h0);
        check("rst_d_err", {31'h0, d_err}, 32'h0);

        // Tie at the first edge after release: D, I, D, I every two cycles.
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{(k % 2 == 0), mem_data((k % 2 == 0) ? 32'h200 : 32'h100)});
            rc[k] = 0;
        end
        rst = 1'b1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 30) begin
            tick(); cyc++;
            if (i_resp || d_resp) begin rc[n] = cyc; n++; end
        end
        i_read = 1'b0; d_read = 1'b0;
        check("tie_count", n, 32'd4);
        check("tie_first", rc[0], 32'd1);
        check("tie_cadence", rc[3], 32'd7);

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            tick();
            if (v.port) begin
                d_read = v.rd; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_mbe = v.mbe;
            end else begin
                i_read = 1'b1; i_addr = v.addr;
            end
            mem_lat = int'(v.lat);
            sb.push_back('{v.port, mem_data(v.exp_addr)});
            got = 1'b0; seen = 1'b0; cyc = 0; n = 0;
            while (!got && cyc < 40) begin
                tick(); cyc++;
                if (!seen && (pmem_read || pmem_write)) begin
                    seen = 1'b1;
                    check("vec_addr", pmem_addr, v.exp_addr);
                    check("vec_mbe", {28'h0, pmem_mbe}, {28'h0, v.exp_mbe});
                    check("vec_write", {31'h0, pmem_write}, {31'h0, v.exp_wr});
                    check("vec_read", {31'h0, pmem_read}, {31'h0, ~v.exp_wr});
                    check("vec_wdata", pmem_wdata, v.exp_wdata);
                    if (v.port) check("vec_owner", {31'h0, owner}, 32'h1);
                end
                if (i_resp || d_resp) begin got = 1'b1; n = cyc; end
            end
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
            check("vec_strobe", {31'h0, seen}, 32'h1);
            check("vec_latency", n, 32'(1 + int'(v.lat)));
        end

        // Data request arrives while a fetch waits five cycles for memory.
        tick();
        i_addr = 32'h0000_0300; i_read = 1'b1; mem_lat = 5;
        sb.push_back('{1'b0, mem_data(32'h300)});
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("busy_fetch_addr", pmem_addr, 32'h0000_0300);
            check("busy_fetch_read", {31'h0, pmem_read}, 32'h1);
            check("busy_no_d_resp", {31'h0, d_resp}, 32'h0);
            if (k == 1) begin
                d_addr = 32'h0000_0400; d_read = 1'b1;
                sb.push_back('{1'b1, mem_data(32'h400)});
            end
        end
        tick();
        check("busy_i_resp", {31'h0, i_resp}, 32'h1);
        i_read = 1'b0; mem_lat = 0;
        tick();
        check("turnaround_idle", {31'h0, busy}, 32'h0);
        tick();
        check("data_after_idle_addr", pmem_addr, 32'h0000_0400);
        check("data_after_idle_owner", {31'h0, owner}, 32'h1);
        check("data_after_idle_resp", {31'h0, d_resp}, 32'h1);
        d_read = 1'b0;

        // Read and write together: executed as a write, error flag sticks.
        tick();
        check("illegal_err_before", {31'h0, d_err}, 32'h0);
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0600; d_wdata = 32'h1234_5678; d_mbe = 4'hF;
        sb.push_back('{1'b1, mem_data(32'h600)});
        tick();
        check("illegal_write", {31'h0, pmem_write}, 32'h1);
        check("illegal_no_read", {31'h0, pmem_read}, 32'h0);
        check("illegal_wdata", pmem_wdata, 32'h1234_5678);
        check("illegal_resp", {31'h0, d_resp}, 32'h1);
        d_read = 1'b0; d_write = 1'b0;
        tick();
        check("illegal_err_set", {31'h0, d_err}, 32'h1);
        i_addr = 32'h0000_0700; i_read = 1'b1;
        sb.push_back('{1'b0, mem_data(32'h700)});
        tick();
        i_read = 1'b0;
        tick();
        check("illegal_err_sticky", {31'h0, d_err}, 32'h1);

        // Reset two cycles into a data read, then a stray memory response.
        d_addr = 32'h0000_0500; d_read = 1'b1; mem_lat = 20;
        sb.push_back('{1'b1, mem_data(32'h500)});
        tick();
        tick();
        check("pre_reset_strobe", {31'h0, pmem_read}, 32'h1);
        rst = 1'b0;
        #1;
        check("reset_pmem_read", {31'h0, pmem_read}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_no_d_resp", {31'h0, d_resp}, 32'h0);
        check("reset_d_err", {31'h0, d_err}, 32'h0);
        d_read = 1'b0;
        sb.delete();
        mem_en = 1'b0; pmem_resp = 1'b1; pmem_rdata = 32'hDEAD_BEEF; mem_lat = 0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stray_resp_ignored", {30'h0, i_resp, d_resp}, 32'h0);
            check("stray_not_busy", {31'h0, busy}, 32'h0);
        end
        pmem_resp = 1'b0; pmem_rdata = 32'h0; mem_en = 1'b1;
        tick();
        check("scoreboard_empty", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
